// File: rtl/glb_stream_player_mc.sv
// Multi-channel preloaded token stream player with ready/valid replay, optional
// LFSR-driven valid gaps and a shared first-valid-to-sink-done cycle counter.
module glb_stream_player_mc #(
  parameter int unsigned      NUM_CH     = 3,
  parameter int unsigned      DATA_WIDTH = 17,
  parameter int unsigned      DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100,
  parameter logic [15:0]      LFSR_SEED  = 16'hACE1,
  localparam int unsigned     CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         ld_valid,
  input  logic [CH_W-1:0]              ld_ch,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         start,
  input  logic [NUM_CH-1:0]            gap_en,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  input  logic                         sink_done,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            done_tok,
  output logic                         ld_err,
  output logic [63:0]                  cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CH_W:0] NCH_W   = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;
  typedef enum logic [1:0] {CNT_IDLE, CNT_ARMED, CNT_RUN, CNT_FROZEN} cnt_state_t;

  logic              ld_ch_ok;
  logic [NUM_CH-1:0] ld_acc_v;

  assign ld_ch_ok = ({1'b0, ld_ch} < NCH_W);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [15:0] SEED_RAW = LFSR_SEED ^ 16'(c + 1);
    localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_cnt, rd_ptr;
    logic                  vld_q, tok_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [15:0]           lfsr;
    logic                  hs, last_hs, can_present, present, ld_acc;

    // rd_ptr is the prefetch pointer: it indexes the next word to present, so
    // the last handshake is the one taken while rd_ptr already equals wr_cnt.
    always_comb begin
      hs          = vld_q & out_ready[c];
      last_hs     = hs && (rd_ptr == wr_cnt);
      can_present = (!vld_q || hs) && (rd_ptr < wr_cnt) && (!gap_en[c] || lfsr[0]);
      ld_acc      = ld_valid && ld_ch_ok && (ld_ch == CH_W'(c)) && (state_q == ST_IDLE)
                    && (wr_cnt < DEPTH_W) && !start;
      state_d     = state_q;
      present     = 1'b0;
      unique case (state_q)
        ST_IDLE: if (start) begin
          if (wr_cnt == '0) state_d = ST_DONE;
          else begin
            state_d = ST_PLAY;
            present = can_present;
          end
        end
        ST_PLAY: if (last_hs) state_d = ST_DONE;
                 else present = can_present;
        default: ;
      endcase
      if (flush) begin
        state_d = ST_IDLE;
        present = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        wr_cnt  <= '0;
        rd_ptr  <= '0;
        vld_q   <= 1'b0;
        dat_q   <= '0;
        tok_q   <= 1'b0;
        lfsr    <= SEED;
      end else begin
        state_q <= state_d;
        if (ld_acc) wr_cnt <= wr_cnt + 1'b1;
        if (flush) begin
          rd_ptr <= '0;
          vld_q  <= 1'b0;
          tok_q  <= 1'b0;
          lfsr   <= SEED;
        end else begin
          if (state_q == ST_PLAY) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          vld_q <= present | (vld_q & ~hs);
          if (present) begin
            dat_q  <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (hs && (dat_q == DONE_TOKEN)) tok_q <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (ld_acc) mem[wr_cnt[AW-1:0]] <= ld_data;
    end

    assign ld_acc_v[c]                           = ld_acc;
    assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = dat_q;
    assign out_valid[c]                          = vld_q;
    assign done[c]                               = (state_q == ST_DONE);
    assign done_tok[c]                           = tok_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ld_err <= 1'b0;
    else if (ld_valid && (ld_acc_v == '0)) ld_err <= 1'b1;
  end

  cnt_state_t cnt_q, cnt_d;
  logic [63:0] cnt_val_d;

  always_comb begin
    cnt_d     = cnt_q;
    cnt_val_d = cycle_count;
    unique case (cnt_q)
      CNT_IDLE:  if (start) cnt_d = CNT_ARMED;
      CNT_ARMED: if (|out_valid) begin
        if (sink_done) cnt_d = CNT_FROZEN;
        else begin
          cnt_d     = CNT_RUN;
          cnt_val_d = 64'd1;
        end
      end
      CNT_RUN: if (sink_done) cnt_d = CNT_FROZEN;
               else if (cycle_count != '1) cnt_val_d = cycle_count + 64'd1;
      default: ;
    endcase
    if (flush) begin
      cnt_d     = CNT_IDLE;
      cnt_val_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= CNT_IDLE;
      cycle_count <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cycle_count <= cnt_val_d;
    end
  end

endmodule

// File: tb/tb_glb_stream_player_mc.sv
// Scoreboard bench for glb_stream_player_mc: loaded words are modelled per
// channel, pushed as expectations at start, and popped on every handshake.
module tb_glb_stream_player_mc;
  localparam int NCH = 3;
  localparam int DW  = 17;
  localparam int DEP = 64;

  logic              clk = 1'b0;
  logic              rst_n, flush, ld_valid, start, sink_done;
  logic [1:0]        ld_ch;
  logic [DW-1:0]     ld_data;
  logic [NCH-1:0]    gap_en, out_valid, out_ready, done, done_tok;
  logic [NCH*DW-1:0] out_data;
  logic              ld_err;
  logic [63:0]       cycle_count;

  glb_stream_player_mc #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP),
                         .DONE_TOKEN(17'h10100), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ld_valid(ld_valid), .ld_ch(ld_ch),
    .ld_data(ld_data), .start(start), .gap_en(gap_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sink_done(sink_done), .done(done),
    .done_tok(done_tok), .ld_err(ld_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q [NCH][$];
  logic [DW-1:0] exp_q   [NCH][$];
  logic [NCH-1:0] idle = '1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor and hold-stability checks, sampled on the falling edge.
  logic [NCH-1:0] pv = '0, pr = '0;
  logic [DW-1:0]  pd [NCH];
  logic           chk_stable = 1'b0;
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (chk_stable && pv[c] && !pr[c]) begin
        check("hold_valid", 64'(out_valid[c]), 64'd1);
        check("hold_data", 64'(out_data[c*DW +: DW]), 64'(pd[c]));
      end
      if (out_valid[c] && out_ready[c]) begin
        if (exp_q[c].size() == 0) check("extra_beat", 64'(exp_q[c].size()), 64'd1);
        else check("beat_data", 64'(out_data[c*DW +: DW]), 64'(exp_q[c].pop_front()));
      end
      pv[c] = out_valid[c];
      pr[c] = out_ready[c];
      pd[c] = out_data[c*DW +: DW];
    end
    chk_stable = rst_n && !flush;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp;
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    idle = '1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; ld_valid = 1'b0; start = 1'b0; sink_done = 1'b0;
    ld_ch = '0; ld_data = '0;
    clear_exp();
    for (int c = 0; c < NCH; c++) model_q[c].delete();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tok", 64'(done_tok), 64'd0);
    check("rst_lderr", 64'(ld_err), 64'd0);
    check("rst_cnt", cycle_count, 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic do_flush;
    clear_exp();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_done", 64'(done), 64'd0);
    check("fl_tok", 64'(done_tok), 64'd0);
    check("fl_cnt", cycle_count, 64'd0);
  endtask

  task automatic load(input int ch, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_ch = 2'(ch); ld_data = d;
    if (ch < NCH && idle[ch] && model_q[ch].size() < DEP) model_q[ch].push_back(d);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start;
    for (int c = 0; c < NCH; c++)
      if (idle[c]) begin
        foreach (model_q[c][i]) exp_q[c].push_back(model_q[c][i]);
        idle[c] = 1'b0;
      end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [NCH-1:0] mask, input int budget, input bit rnd);
    int n = 0;
    while (((done & mask) != mask) && n < budget) begin
      if (rnd) out_ready = NCH'($urandom);
      tick();
      n++;
    end
    check("done_wait", 64'(done & mask), 64'(mask));
  endtask

  task automatic check_drained;
    for (int c = 0; c < NCH; c++) check("drained", 64'(exp_q[c].size()), 64'd0);
  endtask

  initial begin
    gap_en = '0; out_ready = '1;

    // Three-channel basic playback with per-cycle timing
    do_reset();
    load(0, 17'd5); load(0, 17'd6); load(0, 17'd7); load(1, 17'd1);
    pulse_start();
    check("c1_valid", 64'(out_valid), 64'b011);
    check("c1_done", 64'(done), 64'b100);
    check("c1_d0", 64'(out_data[0 +: DW]), 64'd5);
    tick();
    check("c2_valid", 64'(out_valid), 64'b001);
    check("c2_done", 64'(done), 64'b110);
    tick();
    check("c3_d0", 64'(out_data[0 +: DW]), 64'd7);
    tick();
    check("c4_valid", 64'(out_valid), 64'b000);
    check("c4_done", 64'(done), 64'b111);
    check_drained();

    // Backpressure on ch0
    do_reset();
    load(0, 17'h0000A); load(0, 17'h0000B);
    out_ready = 3'b110;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 64'(out_valid[0]), 64'd1);
      check("bp_data", 64'(out_data[0 +: DW]), 64'h0000A);
      if (i < 3) tick();
    end
    out_ready = '1;
    tick();
    check("bp_next", 64'(out_data[0 +: DW]), 64'h0000B);
    tick();
    check("bp_done", 64'(done[0]), 64'd1);
    check_drained();

    // Done token detection; unstarted channel stays clear
    do_reset();
    load(0, 17'h00003); load(0, 17'h10100);
    pulse_start();
    tick();
    check("tok_pre", 64'(done_tok[0]), 64'd0);
    tick();
    check("tok_set", 64'(done_tok[0]), 64'd1);
    do_flush();
    load(1, 17'h10100);
    repeat (5) tick();
    check("tok_idle", 64'(done_tok), 64'd0);

    // Overfill, load in PLAY, load with start, bad channel
    do_reset();
    for (int i = 0; i < DEP; i++) load(0, DW'(i + 100));
    check("fill_err0", 64'(ld_err), 64'd0);
    load(0, 17'h1FFFF);
    check("fill_err1", 64'(ld_err), 64'd1);
    pulse_start();
    wait_done(3'b001, 200, 1'b0);
    check_drained();
    do_reset();
    load(0, 17'd1); load(0, 17'd2);
    out_ready = 3'b110;
    pulse_start();
    load(0, 17'h1ABCD);
    check("play_err", 64'(ld_err), 64'd1);
    out_ready = '1;
    wait_done(3'b001, 50, 1'b0);
    check_drained();
    do_flush();
    check("err_kept", 64'(ld_err), 64'd1);
    do_reset();
    load(0, 17'd4);
    ld_valid = 1'b1; ld_ch = 2'd0; ld_data = 17'd9;
    pulse_start();
    ld_valid = 1'b0;
    check("ldst_err", 64'(ld_err), 64'd1);
    wait_done(3'b001, 50, 1'b0);
    check_drained();
    do_reset();
    load(3, 17'd1);
    check("badch_err", 64'(ld_err), 64'd1);

    // Reset mid-playback
    do_reset();
    load(2, 17'd3);
    out_ready = '0;
    pulse_start();
    check("mid_valid", 64'(out_valid[2]), 64'd1);
    do_reset();
    out_ready = '1;

    // Random gaps with random backpressure
    do_reset();
    gap_en = '1;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < DEP; i++) load(c, DW'($urandom));
    pulse_start();
    wait_done('1, 3000, 1'b1);
    check_drained();
    gap_en = '0; out_ready = '1;

    // Cycle counter, freeze, flush, replay
    do_reset();
    load(0, 17'h00021); load(0, 17'h00022); load(0, 17'h00023);
    pulse_start();
    repeat (39) tick();
    sink_done = 1'b1;
    tick();
    sink_done = 1'b0;
    check("cnt_39", cycle_count, 64'd39);
    repeat (5) tick();
    check("cnt_frz", cycle_count, 64'd39);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check("cnt_norearm", cycle_count, 64'd39);
    do_flush();
    pulse_start();
    wait_done('1, 50, 1'b0);
    check_drained();
    check("cnt_rerun", 64'(cycle_count > 64'd0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/glb_stream_player_mc.md
Name: glb_stream_player_mc

Overview:
- Parametrised, multi-channel successor to the single-channel GLB write driver used around the PE_onyx harness.
- Per channel it buffers a preloaded token stream and replays it over ready/valid.
- Optional pseudo-random valid gaps per channel generalise the fixed RAN_SHITF behaviour.
- A shared 64-bit cycle counter measures latency from the first valid beat until the sink reports done.

Parameters:
- NUM_CH, 3, number of independent output channels.
- DATA_WIDTH, 17, token width; MSB set marks a control token.
- DEPTH, 64, words buffered per channel; power of two, at least 2.
- DONE_TOKEN, 17'h10100, value flagged as stream-done token.
- LFSR_SEED, 16'hACE1, base seed; channel c uses LFSR_SEED ^ (c+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous replay restart; buffer contents kept
- ld_valid  in  1  load strobe
- ld_ch  in  CH_W=max(1,clog2(NUM_CH))  target channel of load
- ld_data  in  DATA_WIDTH  word to append
- start  in  1  single-cycle pulse, begin playback on all channels
- gap_en  in  NUM_CH  per-channel random valid-gap enable
- out_data  out  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  NUM_CH  per-channel valid
- out_ready  in  NUM_CH  per-channel ready from DUT
- sink_done  in  1  sink finished; stops cycle counter
- done  out  NUM_CH  channel finished playback
- done_tok  out  NUM_CH  sticky, DONE_TOKEN transferred on channel
- ld_err  out  1  sticky, load dropped
- cycle_count  out  64  measured cycles

Behaviour:
- Reset, checked at posedge when rst_n=0:
  - all outputs 0; state IDLE; wr_cnt=0; rd_ptr=0.
  - LFSRs reseeded, never zero; counter disarmed.
  - Reset mid-playback aborts immediately; out_valid is 0 on the next cycle.
- Per-channel FSM, IDLE -> PLAY -> DONE:
  - IDLE -> PLAY on start when wr_cnt>0.
  - IDLE -> DONE on start when wr_cnt==0; done=1 on the next cycle.
  - PLAY -> DONE on the handshake of word wr_cnt-1.
  - DONE holds until flush or reset.
- Load:
  - Accepted only when the target channel is IDLE, ld_ch<NUM_CH and wr_cnt<DEPTH.
  - An accepted load writes mem[ld_ch][wr_cnt] and increments wr_cnt; wr_cnt is clog2(DEPTH)+1 bits and reaches DEPTH exactly.
  - Any other load is dropped and sets ld_err.
  - Load and start in the same cycle: start wins; the load is dropped and ld_err is set.
- Playback:
  - out_data and out_valid are registered.
  - In PLAY with gap_en[c]=0, out_valid rises the cycle after start.
  - With gap_en[c]=1, an idle channel raises valid only on a cycle where lfsr[c][0]=1.
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle the channel is in PLAY.
  - Once asserted, out_valid stays high and out_data stays stable until out_ready. The LFSR never drops an asserted valid.
  - Handshake = out_valid & out_ready at posedge. rd_ptr increments, and the next word is presented the following cycle with no bubble unless a gap is drawn.
  - Peak throughput is 1 word/cycle/channel. Channels are independent.
  - After the last handshake: out_valid=0 and done[c]=1 on the next cycle.
  - A handshake whose word equals DONE_TOKEN sets done_tok[c]. Playback continues until wr_cnt is exhausted.
- Flush:
  - rd_ptr=0, state IDLE, out_valid=0, done=0, done_tok=0, LFSRs reseeded, counter cleared and disarmed.
  - wr_cnt, memory contents and ld_err are kept; a following start replays identical streams.
  - Flush beats start in the same cycle.
- Cycle counter:
  - Armed by start.
  - Counting begins on the first cycle at which any out_valid is sampled high; that cycle counts as 1.
  - Increments each cycle while sink_done=0; freezes on the first cycle sink_done=1 (that cycle is not counted).
  - Saturates at 2^64-1. A later start while frozen does not re-arm; only flush or reset clears it.
- Memory: one DEPTH x DATA_WIDTH array per channel. Reads are synchronous; rd_ptr is prefetched so there is no bubble.

Test Plan:
- NUM_CH=3: load ch0 {5,6,7}, ch1 {1}, ch2 nothing; start with gap_en=0 and ready=1. Ch0 valid on cycles 1-3 with 5,6,7, done[0] on cycle 4. Ch1 valid cycle 1 only. done[2]=1 on cycle 1.
- Ch0 {A,B}; hold out_ready[0]=0 for 4 cycles after valid rises. out_valid stays 1 and out_data stays A for all 4 cycles; B follows one cycle after the A handshake.
- Ch0 {0x00003, 0x10100}, ready=1. done_tok[0]=1 the cycle after the second handshake. Load 0x10100 into ch1 but never start: done_tok[1] stays 0.
- Load DEPTH+1 words into ch0. wr_cnt=DEPTH and ld_err=1. Load during PLAY: ld_err=1 and the stream is unchanged.
- gap_en=3'b111, ready toggling randomly, 64 words per channel. All words arrive in order with no duplicates, and valid never drops before its handshake.
- Counter: start; valid at cycle 1; sink_done rises at cycle 40. cycle_count=39 and frozen. Flush gives 0; replay gives the same word sequence.
